// File: rtl/bsg_halfpod_seq_pkg.sv
// Shared state encoding and constants for the halfpod link bring-up sequencer.
package bsg_halfpod_seq_pkg;

    localparam int unsigned bsg_halfpod_seq_phases_gp = 5;

    // DONE sits one past the last timed phase so the encoding tracks the phase count.
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ASSERT     = 3'd1,
        UPLINK     = 3'd2,
        DOWNLINK   = 3'd3,
        TOKEN      = 3'd4,
        DOWNSTREAM = 3'd5,
        DONE       = 3'(bsg_halfpod_seq_phases_gp + 1)
    } bsg_halfpod_seq_state_e;

endpackage

// File: rtl/bsg_halfpod_seq_hold_ctr.sv
// Clearable phase-hold up-counter with a terminal compare against the latched hold value.
module bsg_halfpod_seq_hold_ctr #(
    parameter int hold_width_p = 8
) (
    input  logic                    clk_i,
    input  logic                    async_reset_n_i,
    input  logic                    clear_i,
    input  logic [hold_width_p-1:0] hold_i,
    output logic                    term_o
);

    logic [hold_width_p-1:0] count_r;

    assign term_o = (count_r == hold_i);

    // Stops at the terminal value, so a maximal hold can never wrap back to zero.
    always_ff @(posedge clk_i or negedge async_reset_n_i) begin
        if (!async_reset_n_i) begin
            count_r <= '0;
        end else if (clear_i) begin
            count_r <= '0;
        end else if (!term_o) begin
            count_r <= count_r + {{(hold_width_p-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/bsg_halfpod_link_bringup_seq.sv
// Ordered SDR link / core reset-release sequencer for a halfpod.
// Optional BSG_HALFPOD_SEQ_ABORT_EN adds an abort_i port that returns the block to IDLE.
module bsg_halfpod_link_bringup_seq
    import bsg_halfpod_seq_pkg::*;
#(
    parameter int num_chan_p   = 3,
    parameter int hold_width_p = 8
) (
    input  logic                    clk_i,
    input  logic                    async_reset_n_i,
    input  logic                    start_i,
`ifdef BSG_HALFPOD_SEQ_ABORT_EN
    input  logic                    abort_i,
`endif
    input  logic [num_chan_p-1:0]   en_mask_i,
    input  logic [hold_width_p-1:0] hold_cycles_i,
    output logic [num_chan_p-1:0]   token_reset_o,
    output logic [num_chan_p-1:0]   uplink_reset_o,
    output logic [num_chan_p-1:0]   downlink_reset_o,
    output logic [num_chan_p-1:0]   downstream_reset_o,
    output logic [num_chan_p-1:0]   link_disable_o,
    output logic                    core_reset_o,
    output logic                    busy_o,
    output logic                    done_o
);

    bsg_halfpod_seq_state_e  state_r;
    logic [num_chan_p-1:0]   mask_r;
    logic [hold_width_p-1:0] hold_r;
    logic                    abort_w;
    logic                    ctr_clear;
    logic                    ctr_term;

`ifdef BSG_HALFPOD_SEQ_ABORT_EN
    assign abort_w = abort_i;
`else
    assign abort_w = 1'b0;
`endif

    // The counter idles at zero outside a sequence and restarts on every phase change.
    assign ctr_clear = !busy_o || ctr_term || abort_w;

    bsg_halfpod_seq_hold_ctr #(
        .hold_width_p (hold_width_p)
    ) hold_ctr (
        .clk_i           (clk_i),
        .async_reset_n_i (async_reset_n_i),
        .clear_i         (ctr_clear),
        .hold_i          (hold_r),
        .term_o          (ctr_term)
    );

    always_ff @(posedge clk_i or negedge async_reset_n_i) begin
        if (!async_reset_n_i) begin
            state_r            <= IDLE;
            mask_r             <= '0;
            hold_r             <= '0;
            token_reset_o      <= '1;
            uplink_reset_o     <= '1;
            downlink_reset_o   <= '1;
            downstream_reset_o <= '1;
            link_disable_o     <= '1;
            core_reset_o       <= 1'b1;
            busy_o             <= 1'b0;
            done_o             <= 1'b0;
        end else if (abort_w) begin
            state_r            <= IDLE;
            token_reset_o      <= '1;
            uplink_reset_o     <= '1;
            downlink_reset_o   <= '1;
            downstream_reset_o <= '1;
            link_disable_o     <= '1;
            core_reset_o       <= 1'b1;
            busy_o             <= 1'b0;
            done_o             <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start_i) begin
                        state_r            <= ASSERT;
                        mask_r             <= en_mask_i;
                        hold_r             <= hold_cycles_i;
                        token_reset_o      <= '1;
                        uplink_reset_o     <= '1;
                        downlink_reset_o   <= '1;
                        downstream_reset_o <= '1;
                        link_disable_o     <= ~en_mask_i;
                        core_reset_o       <= 1'b1;
                        busy_o             <= 1'b1;
                        done_o             <= 1'b0;
                    end
                end
                ASSERT: begin
                    if (ctr_term) begin
                        state_r        <= UPLINK;
                        uplink_reset_o <= uplink_reset_o & ~mask_r;
                    end
                end
                UPLINK: begin
                    if (ctr_term) begin
                        state_r          <= DOWNLINK;
                        downlink_reset_o <= downlink_reset_o & ~mask_r;
                    end
                end
                DOWNLINK: begin
                    if (ctr_term) begin
                        state_r       <= TOKEN;
                        token_reset_o <= token_reset_o & ~mask_r;
                    end
                end
                TOKEN: begin
                    if (ctr_term) begin
                        state_r            <= DOWNSTREAM;
                        downstream_reset_o <= downstream_reset_o & ~mask_r;
                    end
                end
                DOWNSTREAM: begin
                    if (ctr_term) begin
                        state_r      <= DONE;
                        core_reset_o <= 1'b0;
                        busy_o       <= 1'b0;
                        done_o       <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_o  <= 1'b0;
                    done_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bsg_halfpod_link_bringup_seq.sv
// Scoreboard bench for bsg_halfpod_link_bringup_seq against a release-time reference model.
module tb_bsg_halfpod_link_bringup_seq;

    localparam int num_chan_lp   = 3;
    localparam int hold_width_lp = 8;
    localparam logic [17:0] reset_vec_lp = {15'h7fff, 1'b1, 1'b0, 1'b0};

    logic                     clk_i;
    logic                     async_reset_n_i;
    logic                     start_i;
    logic                     abort_i;
    logic [num_chan_lp-1:0]   en_mask_i;
    logic [hold_width_lp-1:0] hold_cycles_i;
    logic [num_chan_lp-1:0]   token_reset_o;
    logic [num_chan_lp-1:0]   uplink_reset_o;
    logic [num_chan_lp-1:0]   downlink_reset_o;
    logic [num_chan_lp-1:0]   downstream_reset_o;
    logic [num_chan_lp-1:0]   link_disable_o;
    logic                     core_reset_o;
    logic                     busy_o;
    logic                     done_o;

    bsg_halfpod_link_bringup_seq #(
        .num_chan_p   (num_chan_lp),
        .hold_width_p (hold_width_lp)
    ) dut (
        .clk_i              (clk_i),
        .async_reset_n_i    (async_reset_n_i),
        .start_i            (start_i),
`ifdef BSG_HALFPOD_SEQ_ABORT_EN
        .abort_i            (abort_i),
`endif
        .en_mask_i          (en_mask_i),
        .hold_cycles_i      (hold_cycles_i),
        .token_reset_o      (token_reset_o),
        .uplink_reset_o     (uplink_reset_o),
        .downlink_reset_o   (downlink_reset_o),
        .downstream_reset_o (downstream_reset_o),
        .link_disable_o     (link_disable_o),
        .core_reset_o       (core_reset_o),
        .busy_o             (busy_o),
        .done_o             (done_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle_count = 0;
    logic [17:0] exp_q[$];

    // Reference model: a sequence is just "cycles since accepted start" plus latched mask/hold.
    bit                     m_running = 1'b0;
    int                     m_t = 0;
    int                     m_h = 0;
    logic [num_chan_lp-1:0] m_mask = '0;

    function automatic int m_final();
        return 5 * (m_h + 1) + 1;
    endfunction

    function automatic logic [17:0] model_out();
        logic [num_chan_lp-1:0] tk, up, dn, ds;
        logic core;
        if (!m_running) return reset_vec_lp;
        for (int c = 0; c < num_chan_lp; c++) begin
            up[c] = !(m_mask[c] && m_t >= 1 * (m_h + 1) + 1);
            dn[c] = !(m_mask[c] && m_t >= 2 * (m_h + 1) + 1);
            tk[c] = !(m_mask[c] && m_t >= 3 * (m_h + 1) + 1);
            ds[c] = !(m_mask[c] && m_t >= 4 * (m_h + 1) + 1);
        end
        core = (m_t < m_final());
        return {tk, up, dn, ds, ~m_mask, core, core, !core};
    endfunction

    function automatic logic [17:0] actual_vec();
        return {token_reset_o, uplink_reset_o, downlink_reset_o, downstream_reset_o,
                link_disable_o, core_reset_o, busy_o, done_o};
    endfunction

    task automatic check_output(input string name, input logic [17:0] got, input logic [17:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cycle_count, got, want);
        end
    endtask

    task automatic apply_stimulus(input bit start, input logic [num_chan_lp-1:0] mask,
                                  input logic [hold_width_lp-1:0] hold, input bit abort);
        bit busy_now;
        @(negedge clk_i);
        start_i       = start;
        en_mask_i     = mask;
        hold_cycles_i = hold;
`ifdef BSG_HALFPOD_SEQ_ABORT_EN
        abort_i       = abort;
`else
        abort_i       = 1'b0;
`endif
        busy_now = m_running && (m_t < m_final());
        if (abort_i) begin
            m_running = 1'b0;
        end else if (start && !busy_now) begin
            m_running = 1'b1;
            m_t       = 1;
            m_mask    = mask;
            m_h       = int'(hold);
        end else if (busy_now) begin
            m_t++;
        end
        exp_q.push_back(model_out());
    endtask

    task automatic run_idle(input int n);
        for (int i = 0; i < n; i++)
            apply_stimulus(1'b0, num_chan_lp'($urandom), hold_width_lp'($urandom), 1'b0);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk_i);
        async_reset_n_i = 1'b0;
        start_i = 1'b0;
        abort_i = 1'b0;
        m_running = 1'b0;
        #1;
        check_output("async_reset_now", actual_vec(), reset_vec_lp);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(reset_vec_lp);
            @(negedge clk_i);
        end
        async_reset_n_i = 1'b1;
        #1;
    endtask

    // Monitor: compares every sampled cycle against the oldest queued expectation.
    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            cycle_count++;
            if (exp_q.size() > 0) check_output("outputs", actual_vec(), exp_q.pop_front());
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        async_reset_n_i = 1'b0;
        start_i = 1'b0;
        abort_i = 1'b0;
        en_mask_i = '0;
        hold_cycles_i = '0;
        #12;
        check_output("reset_values", actual_vec(), reset_vec_lp);
        do_reset(2);

        $display("[TB] full sequence, mask 111, H=2");
        apply_stimulus(1'b1, 3'b111, 8'd2, 1'b0);
        run_idle(18);

        $display("[TB] masked channel, mask 101, H=0");
        apply_stimulus(1'b1, 3'b101, 8'd0, 1'b0);
        run_idle(8);

        $display("[TB] ignored inputs while busy");
        apply_stimulus(1'b1, 3'b111, 8'd2, 1'b0);
        run_idle(4);
        apply_stimulus(1'b1, 3'b010, 8'd7, 1'b0);
        run_idle(11);

        $display("[TB] restart from done");
        apply_stimulus(1'b1, 3'b011, 8'd1, 1'b0);
        run_idle(12);

        $display("[TB] async reset mid-sequence");
        apply_stimulus(1'b1, 3'b111, 8'd2, 1'b0);
        run_idle(7);
        do_reset(1);
        apply_stimulus(1'b1, 3'b110, 8'd2, 1'b0);
        run_idle(18);

`ifdef BSG_HALFPOD_SEQ_ABORT_EN
        $display("[TB] abort with simultaneous start");
        apply_stimulus(1'b1, 3'b111, 8'd2, 1'b0);
        run_idle(8);
        apply_stimulus(1'b1, 3'b111, 8'd2, 1'b1);
        run_idle(4);
`endif

        $display("[TB] maximum hold");
        apply_stimulus(1'b1, 3'b101, 8'd255, 1'b0);
        run_idle(1290);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 700; i++) begin
            apply_stimulus($urandom_range(0, 7) == 0, num_chan_lp'($urandom),
                           hold_width_lp'($urandom_range(0, 5)), $urandom_range(0, 63) == 0);
        end

        repeat (3) @(negedge clk_i);
        check_output("queue_drained", 18'(exp_q.size()), 18'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bsg_halfpod_link_bringup_seq.md
# bsg_halfpod_link_bringup_seq

Parametrised hardware bring-up sequencer for the SDR link channels and core reset of a halfpod. Where the previous generation drove each SDR reset phase by hand over individual bsg_tag writes, this block generates the full ordered reset-release sequence automatically. It supports a configurable number of channels, a per-channel enable mask and a programmable phase hold time. It sits between the halfpod tag clients, which supply start, mask and hold, and the SDR link and tile reset inputs.

## Interface
- num_chan_p, default 3: number of SDR link channels sequenced.
- hold_width_p, default 8: width of the phase hold counter and of hold_cycles_i.
- clk_i  in  1  sequencer clock.
- async_reset_n_i  in  1  asynchronous, active-low reset.
- start_i  in  1  bring-up request; a level sampled on each rising edge.
- en_mask_i  in  num_chan_p  channels to bring up; sampled when start is accepted.
- hold_cycles_i  in  hold_width_p  phase hold H; sampled when start is accepted.
- token_reset_o, uplink_reset_o, downlink_reset_o, downstream_reset_o  out  num_chan_p each  per-channel SDR resets, active-high.
- link_disable_o  out  num_chan_p  per-channel SDR disable.
- core_reset_o  out  1  tile core reset, active-high.
- busy_o  out  1  sequence in progress.
- done_o  out  1  sequence complete; core is out of reset.

## Operation
- **States:** IDLE, ASSERT, UPLINK, DOWNLINK, TOKEN, DOWNSTREAM, DONE.
- **IDLE or DONE:** when start_i=1 and busy_o=0, latch en_mask_i and hold_cycles_i, clear the counter and go to ASSERT.
- **start while busy:** start_i while busy_o=1 is ignored.
- **ASSERT:** every reset output = 1. link_disable_o = ~mask_r.
- **Phase exits:** each non-DONE phase exits when the counter equals H_r; the counter clears on each transition.
- **Release order (enabled channels only):**
  - ASSERT→UPLINK releases uplink_reset.
  - UPLINK→DOWNLINK releases downlink_reset.
  - DOWNLINK→TOKEN releases token_reset.
  - TOKEN→DOWNSTREAM releases downstream_reset.
  - DOWNSTREAM→DONE releases core_reset_o.
- **Released bits** stay 0 until the next accepted start or a reset.
- **Disabled channels** (mask_r bit 0) hold all four resets at 1 and link_disable_o at 1 throughout.
- **mask_r = 0:** the sequence still runs and releases the core.
- **Restart from DONE:** all resets re-assert in the first ASSERT cycle and done_o drops.

## Timing
- **Registering:** all outputs are registered; no combinational input-to-output path.
- **Reset values:** state IDLE; every reset output 1; link_disable_o all 1; core_reset_o 1; busy_o 0; done_o 0.
- **Start to busy:** with start_i accepted at edge 0, busy_o=1 and the state is ASSERT from cycle 1.
- **Phase length:** each phase lasts H+1 cycles.
- **Release cycles:**
  - uplink falls at cycle H+2.
  - downlink falls at 2H+3.
  - token falls at 3H+4.
  - downstream falls at 4H+5.
  - core_reset_o falls at 5H+6, the same cycle done_o=1 and busy_o=0.
- **Hold range:** H=0 is legal (1-cycle phases). H=2^hold_width_p−1 must not wrap the counter.
- **Input changes:** changes to en_mask_i or hold_cycles_i during a sequence have no effect.
- **Reset mid-sequence:** async_reset_n_i low mid-sequence immediately returns all outputs to their reset values.

## Configuration
- **BSG_HALFPOD_SEQ_ABORT_EN defined:** adds port abort_i (in, 1).
  - abort_i=1 at any edge forces the next cycle to IDLE with all outputs at their reset values.
  - abort_i wins over a simultaneous start_i.
- **Not defined:** the port is absent and only async_reset_n_i can abort a sequence.

## Structure
- **Package bsg_halfpod_seq_pkg:**
  - state enum bsg_halfpod_seq_state_e.
  - localparam bsg_halfpod_seq_phases_gp = 5.
- **Sub-module bsg_halfpod_seq_hold_ctr:** clearable up-counter of hold_width_p bits with a terminal-compare output against H_r. It is instantiated once.
- **Top module:** holds the FSM, mask and hold registers, and the per-channel output registers.

## Test plan
- **Full sequence:** num_chan_p=3, mask=3'b111, H=2, start at cycle 0.
  - Required: uplink/downlink/token/downstream fall at cycles 4/7/10/13; core_reset_o falls and done_o rises at 16; link_disable_o=0 from cycle 1.
- **Masked channel:** mask=3'b101, H=0.
  - Required: channel 1 resets and disable stay 1; channels 0 and 2 release at cycles 2,3,4,5; done at 6.
- **Ignored inputs while busy:** start_i re-pulsed and hold_cycles_i changed to 7 at cycle 5 with H=2.
  - Required: timing is unchanged, done at 16.
- **Restart from DONE:** after done, assert start again.
  - Required: next cycle all resets=1, done_o=0, busy_o=1; sequence repeats.
- **Async reset mid-sequence:** async_reset_n_i low at cycle 8.
  - Required: outputs immediately return to reset values; start after release runs a full sequence.
- **Abort (with BSG_HALFPOD_SEQ_ABORT_EN):** abort_i together with start_i at cycle 9.
  - Required: IDLE at cycle 10, resets all 1, busy_o=0.
